// File: rtl/seq_mult.sv
// Iterative shift-add multiplier: one multiplier bit per clock, fixed WIDTH+1 cycle latency,
// unsigned or two's-complement operands selected per operation, valid/ready on both sides.
module seq_mult #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   c,
    output logic                 busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t               r_state;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_c;
    logic [WIDTH-1:0]     r_mplier;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_neg;
    logic                 r_out_valid;

    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;

    // Magnitude of the most negative value wraps to itself, which is the correct unsigned 2^(WIDTH-1).
    always_comb begin
        w_abs_a = a;
        w_abs_b = b;
        if (is_signed && a[WIDTH-1]) w_abs_a = ~a + WIDTH'(1);
        if (is_signed && b[WIDTH-1]) w_abs_b = ~b + WIDTH'(1);
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mcand     <= '0;
            r_acc       <= '0;
            r_c         <= '0;
            r_mplier    <= '0;
            r_cnt       <= '0;
            r_neg       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_abs_a};
                        r_mplier <= w_abs_b;
                        r_neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_state  <= CALC;
                    end
                end
                CALC: begin
                    if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= FIX;
                end
                FIX: begin
                    r_c         <= r_neg ? (~r_acc + (2*WIDTH)'(1)) : r_acc;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // in_ready is gated by rst so the source never sees a handshake that reset would swallow.
    assign in_ready  = (r_state == IDLE) && !rst;
    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign c         = r_c;

endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult: directed 32-bit vectors and corner sequences,
// plus random back-to-back traffic on an 8-bit instance, both scoreboarded through queues.
module tb_seq_mult;

    logic        CLK = 1'b0;
    logic        rst;

    logic        iv32, ir32, s32, ov32, or32, busy32;
    logic [31:0] a32, b32;
    logic [63:0] c32;

    logic        iv8, ir8, s8, ov8, or8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] c8;

    int errors = 0;
    int checks = 0;

    logic [63:0] q32[$];
    logic [15:0] q8[$];
    int          stamp8[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [63:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[8];

    seq_mult #(.WIDTH(32)) dut32 (
        .CLK(CLK), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
        .is_signed(s32), .out_valid(ov32), .out_ready(or32), .c(c32), .busy(busy32)
    );

    seq_mult #(.WIDTH(8)) dut8 (
        .CLK(CLK), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .is_signed(s8), .out_valid(ov8), .out_ready(or8), .c(c8), .busy(busy8)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic timeout_fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    task automatic wait_ready32(input string nm);
        int k;
        k = 0;
        while (!ir32 && k < 100) begin
            @(negedge CLK);
            k++;
        end
        if (!ir32) timeout_fail({nm, "_ready"});
    endtask

    // Issue one 32-bit operation with out_ready high; checks latency and the scoreboarded product.
    task automatic op32(input logic [31:0] va, input logic [31:0] vb, input logic vs,
                        input logic [63:0] vexp, input string nm);
        int k;
        logic [63:0] e;
        @(negedge CLK);
        wait_ready32(nm);
        a32 = va; b32 = vb; s32 = vs; iv32 = 1'b1;
        q32.push_back(vexp);
        @(negedge CLK);
        chk({nm, "_busy"}, 64'(busy32), 64'd1);
        k = 0;
        while (!ov32 && k < 200) begin
            iv32 = k[0];
            a32 = $urandom; b32 = $urandom; s32 = k[1];
            @(negedge CLK);
            k++;
        end
        iv32 = 1'b0;
        if (!ov32) begin
            timeout_fail({nm, "_valid"});
            void'(q32.pop_back());
        end else begin
            chk({nm, "_lat"}, 64'(k), 64'd33);
            if (q32.size() == 0) timeout_fail({nm, "_queue"});
            else begin
                e = q32.pop_front();
                chk(nm, c32, e);
            end
        end
    endtask

    initial begin
        int k;
        int issued;
        int done8;
        int cyc;
        int st;
        logic [15:0] e8;
        logic [63:0] e;

        vecs[0] = '{32'd3,         32'd5,         1'b0, 64'h0000_0000_0000_000F, "u_3x5"};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "u_max_sq"};
        vecs[2] = '{32'hFFFF_FFFF, 32'd1,         1'b1, 64'hFFFF_FFFF_FFFF_FFFF, "s_m1x1"};
        vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "s_min_sq"};
        vecs[4] = '{32'h8000_0000, 32'd0,         1'b1, 64'h0,                   "s_min_x0"};
        vecs[5] = '{32'd0,         32'hFFFF_FFFB, 1'b1, 64'h0,                   "s_0xm5"};
        vecs[6] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'hC000_0000_8000_0000, "s_max_x_min"};
        vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000, "u_2p31_sq"};

        rst = 1'b1;
        iv32 = 1'b0; a32 = '0; b32 = '0; s32 = 1'b0; or32 = 1'b1;
        iv8 = 1'b0;  a8 = '0;  b8 = '0;  s8 = 1'b0;  or8 = 1'b1;

        repeat (3) @(negedge CLK);
        chk("rst_in_ready", 64'(ir32), 64'd0);
        chk("rst_out_valid", 64'(ov32), 64'd0);
        chk("rst_busy", 64'(busy32), 64'd0);
        chk("rst_c", c32, 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(ir32), 64'd1);

        for (int i = 0; i < 8; i++)
            op32(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].exp, vecs[i].name);

        // Backpressure: hold DONE for 10 cycles while new operands are thrown at the input.
        @(negedge CLK);
        wait_ready32("bp");
        or32 = 1'b0;
        a32 = 32'd12345; b32 = 32'd678; s32 = 1'b0; iv32 = 1'b1;
        q32.push_back(64'h0000_0000_007F_B6F6);
        @(negedge CLK);
        iv32 = 1'b0;
        k = 0;
        while (!ov32 && k < 200) begin
            @(negedge CLK);
            k++;
        end
        if (!ov32) timeout_fail("bp_valid");
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold_valid", 64'(ov32), 64'd1);
            chk("bp_hold_c", c32, q32[0]);
            chk("bp_hold_in_ready", 64'(ir32), 64'd0);
            iv32 = ~iv32; a32 = $urandom; b32 = $urandom; s32 = ~s32;
            @(negedge CLK);
        end
        iv32 = 1'b0;
        or32 = 1'b1;
        e = q32.pop_front();
        chk("bp_result", c32, e);
        @(negedge CLK);
        chk("bp_after_valid", 64'(ov32), 64'd0);
        chk("bp_after_in_ready", 64'(ir32), 64'd1);
        chk("bp_after_c_kept", c32, e);

        // Reset in the middle of CALC discards the operation.
        wait_ready32("rst_mid");
        a32 = 32'd100; b32 = 32'd100; s32 = 1'b0; iv32 = 1'b1;
        @(negedge CLK);
        iv32 = 1'b0;
        repeat (9) @(negedge CLK);
        rst = 1'b1;
        #1;
        chk("rst_mid_in_ready_low", 64'(ir32), 64'd0);
        @(negedge CLK);
        rst = 1'b0;
        #1;
        chk("rst_mid_out_valid", 64'(ov32), 64'd0);
        chk("rst_mid_c", c32, 64'd0);
        chk("rst_mid_busy", 64'(busy32), 64'd0);
        chk("rst_mid_in_ready", 64'(ir32), 64'd1);
        op32(32'hFFFF_FFF9, 32'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFD6, "s_m7x6");

        // Random back-to-back traffic on the 8-bit instance.
        issued = 0; done8 = 0; cyc = 0;
        while (done8 < 1000 && cyc < 20000) begin
            @(negedge CLK);
            cyc++;
            if (ov8) begin
                if (q8.size() == 0) timeout_fail("rand8_queue");
                else begin
                    e8 = q8.pop_front();
                    st = stamp8.pop_front();
                    chk("rand8_c", 64'(c8), 64'(e8));
                    chk("rand8_lat", 64'(cyc - st), 64'd9);
                end
                done8++;
            end
            if (ir8 && issued < 1000) begin
                a8 = 8'($urandom);
                b8 = 8'($urandom);
                s8 = 1'($urandom_range(0, 1));
                if (s8) e8 = {{8{a8[7]}}, a8} * {{8{b8[7]}}, b8};
                else    e8 = {8'h00, a8} * {8'h00, b8};
                q8.push_back(e8);
                stamp8.push_back(cyc + 1);
                iv8 = 1'b1;
                issued++;
            end else begin
                iv8 = 1'b0;
            end
        end
        chk("rand8_count", 64'(done8), 64'd1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
